codix_risc_ca_core_regs_wr_arb: RTL

Write-port arbiter and initialisation sequencer for the core register file (32 x 32-bit, single write port D0/WA0/WE0).
- Shares the one write port between NREQ writeback sources (ALU, load unit, multiplier) using round-robin valid/ready arbitration.
- After reset, optionally clears registers 1..31 through the same port before any requester is served.
- Sits between the pipeline writeback stages and the register file write pins.

---
 rtl/codix_risc_ca_core_regs_wr_arb_if.sv | 28 ++
 rtl/codix_risc_ca_core_regs_wr_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/codix_risc_ca_core_regs_wr_arb_if.sv
// Write-port bundle between the writeback requesters, the arbiter and the
// register file write pins (D0/WA0/WE0).
interface codix_risc_ca_core_regs_wr_arb_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int GID_W  = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0]      d0;
  logic [ADDR_W-1:0]      wa0;
  logic                   we0;
  logic [GID_W-1:0]       grant_id;
  logic                   busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, d0, wa0, we0, grant_id, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, d0, wa0, we0, grant_id, busy
  );
endinterface

// File: rtl/codix_risc_ca_core_regs_wr_arb.sv
// Round-robin arbiter for the single register-file write port, with an
// optional post-reset sweep that clears r1..r31 before requesters are served.
module codix_risc_ca_core_regs_wr_arb #(
  parameter int NREQ           = 3,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int GID_W          = 2
) (
  input logic clk,
  input logic rst,
  codix_risc_ca_core_regs_wr_arb_if.slave bus
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam state_t            RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [GID_W-1:0]  GID_ONE   = {{(GID_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [GID_W-1:0]  ptr_r, gnt_s, ptr_nxt_s, gid_r;
  logic              found_s;
  logic [ADDR_W-1:0] cnt_r, wa0_r, gnt_addr_s;
  logic [DATA_W-1:0] d0_r, gnt_data_s;
  logic              we0_r;
  logic [NREQ-1:0]   ready_s;

  // Rotating-priority search: first valid requester starting at ptr, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    gnt_s   = {GID_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_r) + k) % NREQ;
      if (!found_s && bus.req_valid[idx]) begin
        found_s = 1'b1;
        gnt_s   = GID_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Winner's payload and the pointer value that follows it
  always_comb begin
    gnt_addr_s = bus.req_addr[gnt_s*ADDR_W +: ADDR_W];
    gnt_data_s = bus.req_data[gnt_s*DATA_W +: DATA_W];
    if (int'(gnt_s) == NREQ - 1) begin
      ptr_nxt_s = {GID_W{1'b0}};
    end else begin
      ptr_nxt_s = gnt_s + GID_ONE;
    end
  end

  // Ready depends only on valid, ptr and state, never on ready itself
  always_comb begin
    ready_s = {NREQ{1'b0}};
    if (!rst && (state_r == ST_RUN) && found_s) begin
      ready_s[gnt_s] = 1'b1;
    end else begin
      ready_s = {NREQ{1'b0}};
    end
  end

  // Next-state logic: INIT leaves once the last register address is issued
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RST_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered write port, clear counter and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_r  <= {DATA_W{1'b0}};
      wa0_r <= {ADDR_W{1'b0}};
      we0_r <= 1'b0;
      gid_r <= {GID_W{1'b0}};
      ptr_r <= {GID_W{1'b0}};
      cnt_r <= ADDR_ONE;
    end else begin
      case (state_r)
        ST_INIT: begin
          we0_r <= 1'b1;
          wa0_r <= cnt_r;
          d0_r  <= {DATA_W{1'b0}};
          cnt_r <= cnt_r + ADDR_ONE;
        end
        ST_RUN: begin
          if (found_s) begin
            // r0 is hard-wired zero: complete the handshake but suppress the write
            we0_r <= (gnt_addr_s != {ADDR_W{1'b0}});
            wa0_r <= gnt_addr_s;
            d0_r  <= gnt_data_s;
            gid_r <= gnt_s;
            ptr_r <= ptr_nxt_s;
          end else begin
            we0_r <= 1'b0;
          end
        end
        default: begin
          we0_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.d0        = d0_r;
  assign bus.wa0       = wa0_r;
  assign bus.we0       = we0_r;
  assign bus.grant_id  = gid_r;
  assign bus.busy      = (state_r == ST_INIT);

endmodule
